// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - runtime-programmable up/down counter with free-running and one-shot modes
//
// Optional feature macro: PRESCALER_EN (adds a 0..PRESCALE-1 advance prescaler).
//
// Ports:
//   clkIN        system clock, rising-edge active
//   nResetIN     asynchronous active-low reset
//   startIN      pulse: latch topIN/dirIN/modeIN, load start value, enter RUN
//   stopIN       pulse: return to IDLE with counter 0 (wins over startIN)
//   enIN         count enable, sampled in RUN
//   dirIN        0 = count up 0..top, 1 = count down top..0
//   modeIN       0 = free-running, 1 = one-shot
//   topIN        inclusive terminal value
//   counterOUT   registered count
//   overflowOUT  registered one-cycle pulse on the terminal advance
//   busyOUT      high in RUN
//   doneOUT      high in DONE
module prog_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clkIN,
  input  logic             nResetIN,
  input  logic             startIN,
  input  logic             stopIN,
  input  logic             enIN,
  input  logic             dirIN,
  input  logic             modeIN,
  input  logic [WIDTH-1:0] topIN,
  output logic [WIDTH-1:0] counterOUT,
  output logic             overflowOUT,
  output logic             busyOUT,
  output logic             doneOUT
);

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_param
    $error("prog_counter: WIDTH or PRESCALE out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_top, w_top_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [WIDTH-1:0] w_term;
  logic             w_tick;

`ifdef PRESCALER_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] r_pre, w_pre_nxt;

  // The main counter only sees the enabled cycle that completes a prescale period.
  assign w_tick = (r_pre == PRE_LAST);
`else
  assign w_tick = 1'b1;
`endif

  // Terminal is the far end of the count range in the latched direction.
  assign w_term = r_dir ? '0 : r_top;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_top_nxt   = r_top;
    w_dir_nxt   = r_dir;
    w_mode_nxt  = r_mode;
    w_ovf_nxt   = 1'b0;
`ifdef PRESCALER_EN
    w_pre_nxt   = r_pre;
`endif
    if (stopIN) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
`ifdef PRESCALER_EN
      w_pre_nxt   = '0;
`endif
    end else if (startIN) begin
      w_state_nxt = S_RUN;
      w_top_nxt   = topIN;
      w_dir_nxt   = dirIN;
      w_mode_nxt  = modeIN;
      w_cnt_nxt   = dirIN ? topIN : '0;
`ifdef PRESCALER_EN
      w_pre_nxt   = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
        end
        S_RUN: begin
          if (enIN) begin
`ifdef PRESCALER_EN
            w_pre_nxt = w_tick ? '0 : (r_pre + PRE_ONE);
`endif
            if (w_tick) begin
              if (r_cnt != w_term) begin
                w_cnt_nxt = r_dir ? (r_cnt - ONE) : (r_cnt + ONE);
              end else if (!r_mode) begin
                // Wrap: pick up a reprogrammed terminal. A down-count reloads
                // from the new value so the count never exceeds the latched top.
                w_top_nxt = topIN;
                w_cnt_nxt = r_dir ? topIN : '0;
                w_ovf_nxt = 1'b1;
              end else begin
                w_ovf_nxt   = 1'b1;
                w_state_nxt = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          w_cnt_nxt = r_cnt;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_top   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_top   <= w_top_nxt;
      r_dir   <= w_dir_nxt;
      r_mode  <= w_mode_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

`ifdef PRESCALER_EN
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_nxt;
    end
  end
`endif

  assign counterOUT  = r_cnt;
  assign overflowOUT = r_ovf;
  assign busyOUT     = (r_state == S_RUN);
  assign doneOUT     = (r_state == S_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - scoreboard testbench for prog_counter
module tb_prog_counter;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
`ifdef PRESCALER_EN
  localparam int P = PRESCALE;
`else
  localparam int P = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             st, sp, en, dr, md;
  logic [WIDTH-1:0] top_in;
  logic [WIDTH-1:0] counter_o;
  logic             ovf_o, busy_o, done_o;

  prog_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clkIN       (clk),
    .nResetIN    (rst_n),
    .startIN     (st),
    .stopIN      (sp),
    .enIN        (en),
    .dirIN       (dr),
    .modeIN      (md),
    .topIN       (top_in),
    .counterOUT  (counter_o),
    .overflowOUT (ovf_o),
    .busyOUT     (busy_o),
    .doneOUT     (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ovf;
    bit busy;
    bit done;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference model: plain integer view of the counter's behaviour.
  bit m_run, m_done, m_dir, m_mode, m_ovf;
  int m_cnt, m_top, m_pre;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_dir = 0; m_mode = 0; m_ovf = 0;
    m_cnt = 0; m_top = 0; m_pre = 0;
  endtask

  task automatic model_step(input bit s_st, input bit s_sp, input bit s_en,
                            input bit s_dr, input bit s_md, input int s_top);
    m_ovf = 0;
    if (s_sp) begin
      m_run = 0; m_done = 0; m_cnt = 0; m_pre = 0;
    end else if (s_st) begin
      m_top = s_top; m_dir = s_dr; m_mode = s_md;
      m_cnt = s_dr ? s_top : 0;
      m_run = 1; m_done = 0; m_pre = 0;
    end else if (m_run && s_en) begin
      m_pre = m_pre + 1;
      if (m_pre == P) begin
        m_pre = 0;
        if ((m_dir && m_cnt == 0) || (!m_dir && m_cnt == m_top)) begin
          m_ovf = 1;
          if (m_mode) begin
            m_run = 0;
            m_done = 1;
          end else begin
            m_top = s_top;
            m_cnt = m_dir ? m_top : 0;
          end
        end else begin
          m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
        end
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.cnt = m_cnt; e.ovf = m_ovf; e.busy = m_run; e.done = m_done;
    q.push_back(e);
  endtask

  // One clock: drive inputs after the falling edge, advance the model at the
  // rising edge, return at the next falling edge.
  task automatic cyc(input bit a_st, input bit a_sp, input bit a_en,
                     input bit a_dr, input bit a_md, input int a_top);
    st = a_st; sp = a_sp; en = a_en; dr = a_dr; md = a_md;
    top_in = WIDTH'(a_top);
    @(posedge clk);
    model_step(a_st, a_sp, a_en, a_dr, a_md, a_top);
    push_expect();
    @(negedge clk);
  endtask

  // Monitor: compares every registered output set against the scoreboard.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("counter", int'(counter_o), mon_e.cnt);
      check("overflow", int'(ovf_o), int'(mon_e.ovf));
      check("busy", int'(busy_o), int'(mon_e.busy));
      check("done", int'(done_o), int'(mon_e.done));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  int guard;
  bit r_dr, r_md;
  int r_top;

  initial begin
    rst_n = 1'b0; st = 0; sp = 0; en = 0; dr = 0; md = 0; top_in = '0;
    model_reset();
    #12;
    check("reset_counter", int'(counter_o), 0);
    check("reset_overflow", int'(ovf_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle ignores enable.
    repeat (3) cyc(0, 0, 1, 0, 0, 3);

    // Free-running up, top 3.
    cyc(1, 0, 1, 0, 0, 3);
    repeat (12 * P) cyc(0, 0, 1, 0, 0, 3);

    // One-shot down, top 5, then hold in DONE.
    cyc(1, 0, 1, 1, 1, 5);
    repeat (6 * P + 12) cyc(0, 0, 1, 0, 0, 5);
    cyc(0, 1, 0, 0, 0, 5);

    // Enable gating with top 2, then restart with top 0.
    cyc(1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 14 * P; i++) cyc(0, 0, (i % 2) == 0, 0, 0, 2);
    cyc(1, 0, 1, 0, 0, 0);
    repeat (6 * P) cyc(0, 0, 1, 0, 0, 0);

    // Reprogram top from 7 to 2 at count 4.
    cyc(1, 0, 1, 0, 0, 7);
    guard = 0;
    while (m_cnt != 4 && guard < 100) begin
      cyc(0, 0, 1, 0, 0, 7);
      guard++;
    end
    check("reach_count4", m_cnt, 4);
    repeat (12 * P) cyc(0, 0, 1, 0, 0, 2);

    // Start and stop together: stop wins.
    cyc(1, 1, 1, 0, 0, 5);
    repeat (3) cyc(0, 0, 1, 0, 0, 5);

    // Asynchronous reset mid-run at count 6.
    cyc(1, 0, 1, 0, 0, 9);
    guard = 0;
    while (m_cnt != 6 && guard < 100) begin
      cyc(0, 0, 1, 0, 0, 9);
      guard++;
    end
    check("reach_count6", m_cnt, 6);
    st = 0; sp = 0; en = 1;
    @(posedge clk);
    model_step(0, 0, 1, 0, 0, 9);
    push_expect();
    #2 rst_n = 1'b0;
    #1;
    check("async_counter", int'(counter_o), 0);
    check("async_overflow", int'(ovf_o), 0);
    check("async_busy", int'(busy_o), 0);
    check("async_done", int'(done_o), 0);
    model_reset();
    q.delete();
    push_expect();
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (4) cyc(0, 0, 1, 0, 0, 9);

    // Prescale check: top 1, up.
    cyc(1, 0, 1, 0, 0, 1);
    repeat (10 * P) cyc(0, 0, 1, 0, 0, 1);

    // Randomised traffic; topIN only changes together with a start pulse.
    r_top = 3; r_dr = 0; r_md = 0;
    for (int i = 0; i < 600; i++) begin
      bit a_st, a_sp, a_en;
      a_st = ($urandom_range(0, 19) == 0);
      a_sp = ($urandom_range(0, 39) == 0);
      a_en = ($urandom_range(0, 3) != 0);
      if (a_st) begin
        r_top = $urandom_range(0, 12);
        r_dr  = 1'($urandom_range(0, 1));
        r_md  = 1'($urandom_range(0, 1));
      end
      cyc(a_st, a_sp, a_en, r_dr, r_md, r_top);
    end

    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised, runtime-programmable successor to the fixed-TOP modulo counter.
- Adds:
  - width parameter
  - runtime terminal value
  - count enable
  - up/down direction
  - free-running and one-shot modes, sequenced by a small start/stop state machine
- Used in the WS2811 driver for bit-period, T0H/T1H and reset-latch timing, where intervals change at runtime.

Parameters:
- WIDTH, 8: counter and terminal-value width in bits; legal range 2..32.
- PRESCALE, 4: advance divisor; used only when PRESCALER_EN is defined; legal range 2..256.

Ports:
- clkIN  input  1  system clock; all state changes on its rising edge.
- nResetIN  input  1  asynchronous active-low reset.
- startIN  input  1  single-cycle pulse: latch topIN/dirIN/modeIN, load the start value, enter RUN.
- stopIN  input  1  single-cycle pulse: abort to IDLE and clear the counter.
- enIN  input  1  count enable, sampled on each edge while in RUN.
- dirIN  input  1  0 = up (0 → top), 1 = down (top → 0).
- modeIN  input  1  0 = free-running, 1 = one-shot.
- topIN  input  WIDTH  terminal value (inclusive); cycle length is topIN+1 advances.
- counterOUT  output  WIDTH  current count, registered.
- overflowOUT  output  1  registered one-cycle pulse, high on the edge where the terminal is reached.
- busyOUT  output  1  high while in RUN.
- doneOUT  output  1  high while in DONE (one-shot complete).

Behaviour:
- Reset:
  - Asserting nResetIN forces state IDLE, counter 0, overflowOUT 0, busyOUT 0, doneOUT 0, and clears the internal latches (top, dir, mode), immediately and regardless of clkIN.
  - Applies mid-operation with no residual pulse after release.
- State IDLE:
  - Counter holds 0; enIN is ignored.
  - startIN → RUN.
- Start (from IDLE, RUN or DONE):
  - Latch topIN → topReg, dirIN → dirReg, modeIN → modeReg.
  - Load counter with 0 (up) or topIN (down); overflowOUT 0.
  - Go to RUN on the next edge.
  - Start in RUN is a restart.
- State RUN, per edge:
  - enIN=0: hold counter, overflowOUT 0.
  - enIN=1 and counter not at terminal: counter ±1, overflowOUT 0.
  - The terminal is topReg (up) or 0 (down).
  - enIN=1 and counter at terminal, modeReg=0:
    - reload the counter (0 up / topReg down) and set overflowOUT 1 for that one cycle
    - re-latch topIN into topReg at this wrap; dirReg is not re-latched
    - stay in RUN
  - enIN=1 and counter at terminal, modeReg=1:
    - counter holds the terminal value, overflowOUT 1 for one cycle
    - go to DONE
- State DONE:
  - Counter holds the terminal value; doneOUT 1; enIN ignored.
  - startIN restarts; stopIN → IDLE.
- Stop: from any state → IDLE, counter 0, overflowOUT 0 on the next edge.
- Simultaneous startIN and stopIN: stop wins.
- topIN=0:
  - Every enabled cycle is terminal.
  - In free-running mode overflowOUT stays high for consecutive enabled cycles and the counter stays 0.
- Timing: overflowOUT and counterOUT are both registered.
  - In free-running mode overflowOUT is coincident with the reloaded counter value.
  - The period is exactly topReg+1 enabled cycles.
- Arithmetic: unsigned WIDTH-bit. The counter never exceeds topReg and never underflows; the terminal check precedes the ±1.
- busyOUT/doneOUT: decoded from the registered state, so no combinational path from the inputs.

Optional Feature:
- Macro: PRESCALER_EN.
- Defined:
  - An internal prescaler counts enabled RUN cycles 0..PRESCALE-1.
  - The main counter advances, and terminal handling occurs, only on the enabled cycle where the prescaler is at PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler is cleared on reset, start and stop, and holds while enIN=0.
  - The free-running period becomes (topReg+1)*PRESCALE enabled cycles.
- Not defined: no prescaler logic exists; the main counter advances on every enabled cycle; PRESCALE is unused.

Test Plan:
- Free-running up: WIDTH=8, topIN=3, dirIN=0, modeIN=0, startIN pulse, enIN=1 constant → counterOUT 0,1,2,3,0,1…; overflowOUT high exactly on each return to 0, every 4 cycles; busyOUT=1.
- One-shot down: topIN=5, dirIN=1, modeIN=1, start, enIN=1 → counterOUT 5,4,3,2,1,0; single overflowOUT pulse; then doneOUT=1, busyOUT=0, counter holds 0 for 10+ cycles.
- Enable gating and topIN=0:
  - topIN=2, up, enIN toggled 1,0,1,0… → counter advances only on enabled edges; overflow every 3 enabled cycles.
  - Restart with topIN=0 → overflowOUT continuously high while enIN=1.
- Reprogram and collisions:
  - Free-running with topIN=7; change topIN to 2 at count 4 → counter continues to 7, wraps, then cycles 0..2.
  - startIN and stopIN in the same cycle → IDLE, counter 0.
- Async reset mid-run: topIN=9 at count 6, pulse nResetIN low between clock edges → counterOUT 0, overflowOUT/busyOUT/doneOUT 0 immediately; enIN ignored until the next startIN.
- Prescaler (PRESCALER_EN, PRESCALE=4): topIN=1, up, enIN=1 → counter changes every 4 cycles; overflowOUT every 8 cycles; without the macro, every 2 cycles.
